// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter,
// registered rise/fall pulses, sticky pending flags with IRQ, saturating event counters.
module multi_edge_detector #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d_i,
  input  logic [WIDTH-1:0]       rise_en_i,
  input  logic [WIDTH-1:0]       fall_en_i,
  input  logic [WIDTH-1:0]       clr_i,
  input  logic                   cnt_clr_i,
  output logic [WIDTH-1:0]       level_o,
  output logic [WIDTH-1:0]       rising_edge,
  output logic [WIDTH-1:0]       falling_edge,
  output logic [WIDTH-1:0]       pending_o,
  output logic                   irq_o,
  output logic [WIDTH*CNT_W-1:0] cnt_o
);

  localparam int              FC_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [FC_W-1:0]  r_fc   [WIDTH];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_f;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pend;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_q;

  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_q = (r_rise & rise_en_i) | (r_fall & fall_en_i);

  // A new level is accepted on the FILTER_CYCLES-th consecutive cycle it differs from f.
  always_comb begin
    w_accept = '0;
    for (int n = 0; n < WIDTH; n++) begin
      w_accept[n] = (w_s[n] != r_f[n]) && (r_fc[n] == FC_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f    <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int n = 0; n < WIDTH; n++) r_fc[n] <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        if (w_s[n] == r_f[n]) begin
          r_fc[n] <= '0;
        end else if (w_accept[n]) begin
          r_f[n]  <= w_s[n];
          r_fc[n] <= '0;
        end else begin
          r_fc[n] <= r_fc[n] + 1'b1;
        end
      end
      r_rise <= w_accept & w_s;
      r_fall <= w_accept & ~w_s;
    end
  end

  // Set beats clear; a clear on an event cycle restarts the counter at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      for (int n = 0; n < WIDTH; n++) r_cnt[n] <= '0;
    end else begin
      r_pend <= w_q | (r_pend & ~clr_i);
      for (int n = 0; n < WIDTH; n++) begin
        if (w_q[n] && cnt_clr_i) begin
          r_cnt[n] <= CNT_W'(1);
        end else if (cnt_clr_i) begin
          r_cnt[n] <= '0;
        end else if (w_q[n] && (r_cnt[n] != CNT_MAX)) begin
          r_cnt[n] <= r_cnt[n] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int n = 0; n < WIDTH; n++) cnt_o[n*CNT_W +: CNT_W] = r_cnt[n];
  end

  assign level_o      = r_f;
  assign rising_edge  = r_rise;
  assign falling_edge = r_fall;
  assign pending_o    = r_pend;
  assign irq_o        = |r_pend;

endmodule
